consec_run_detector: RTL and testbench

Parametrised multi-lane consecutive-ones detector, successor to the fixed 4-input / 4-bit shift register / run-of-4 design. A round-robin select counter serialises `LANES` input bits through a mux into a `DEPTH`-bit history shift register. A saturating run-length counter compares the current run of consecutive ones against a runtime threshold and raises a level flag plus a one-cycle rising-edge pulse. The block sits between the lane inputs and downstream status logic; a sample-enable lets the sampling rate be slower than `CLK`.

---
 rtl/consec_run_detector.sv | 183 ++++++++++++++++++
 tb/tb_consec_run_detector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/consec_run_detector.sv
// -----------------------------------------------------------------------------
// consec_run_detector
//
// Multi-lane consecutive-ones detector. A round-robin select counter walks the
// LANES inputs one per enabled edge; the selected bit is shifted into a
// DEPTH-bit history register and drives a saturating run-length counter. A
// level flag (consec) reports that the current run of ones has reached a
// runtime threshold, and rise pulses for one CLK cycle when that flag goes
// from 0 to 1.
//
// Optional feature macro: CONSEC_ZERO_DET_EN
//   defined   : adds a saturating zero-run counter; zrun flags runs of zeros
//               that reach the same threshold.
//   undefined : no zero-run counter exists and zrun is tied to 0.
//   The port list is identical in both builds.
//
// Parameters
//   LANES  number of input lanes (>= 2)
//   DEPTH  history shift register width (>= 2)
//   CNT_W  run-length counter / threshold width
//
// Ports
//   CLK      in   sole clock, rising edge
//   RST      in   synchronous active-high reset (priority over en)
//   en       in   sample enable
//   lanes_in in   [LANES]  parallel lane inputs
//   thresh   in   [CNT_W]  run threshold, 0 disables detection
//   SEL      out  [SEL_W]  current lane select
//   mux_bit  out  lanes_in[SEL], combinational
//   sr_out   out  [DEPTH]  sample history, bit 0 newest
//   run_len  out  [CNT_W]  current run of ones, saturating
//   consec   out  run_len >= thresh (thresh != 0)
//   rise     out  one-cycle pulse on consec 0->1
//   zrun     out  zero-run flag (0 unless CONSEC_ZERO_DET_EN)
// -----------------------------------------------------------------------------
module consec_run_detector #(
    parameter int LANES = 4,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic [LANES-1:0] lanes_in,
    input  logic [CNT_W-1:0] thresh,
    output logic [SEL_W-1:0] SEL,
    output logic             mux_bit,
    output logic [DEPTH-1:0] sr_out,
    output logic [CNT_W-1:0] run_len,
    output logic             consec,
    output logic             rise,
    output logic             zrun
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(LANES - 1);

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    // Threshold compare shared by the ones and zeros detectors; a zero
    // threshold disables detection rather than matching every count.
    function automatic logic thr_met(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] thr);
        return (thr != {CNT_W{1'b0}}) && (cnt >= thr);
    endfunction

    logic [SEL_W-1:0] sel_q,       sel_d;
    logic [DEPTH-1:0] sr_q,        sr_d;
    logic [CNT_W-1:0] run_len_q,   run_len_d;
    logic             consec_dly_q, consec_dly_d;
    logic             mux_bit_s;
    logic             consec_s;

    // Lane mux: SEL never leaves 0..LANES-1, so the index is always valid.
    always_comb begin
        mux_bit_s = lanes_in[sel_q];
    end

    // Next-state for the select counter, history register and run counter.
    always_comb begin
        sel_d     = sel_q;
        sr_d      = sr_q;
        run_len_d = run_len_q;
        if (en) begin
            if (sel_q == SEL_LAST) begin
                sel_d = {SEL_W{1'b0}};
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
            sr_d = {sr_q[DEPTH-2:0], mux_bit_s};
            if (mux_bit_s) begin
                run_len_d = sat_inc(run_len_q);
            end else begin
                run_len_d = {CNT_W{1'b0}};
            end
        end else begin
            sel_d     = sel_q;
            sr_d      = sr_q;
            run_len_d = run_len_q;
        end
    end

    // Level flag decoded from registered count; rise compares against the
    // flag value captured on the previous CLK edge (captured regardless of en
    // so the pulse is exactly one CLK cycle wide).
    always_comb begin
        consec_s     = thr_met(run_len_q, thresh);
        consec_dly_d = consec_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sel_q        <= {SEL_W{1'b0}};
            sr_q         <= {DEPTH{1'b0}};
            run_len_q    <= {CNT_W{1'b0}};
            consec_dly_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            sr_q         <= sr_d;
            run_len_q    <= run_len_d;
            consec_dly_q <= consec_dly_d;
        end
    end

`ifdef CONSEC_ZERO_DET_EN
    logic [CNT_W-1:0] zero_len_q, zero_len_d;

    // Zero-run counter mirrors the ones counter with the bit sense inverted.
    always_comb begin
        zero_len_d = zero_len_q;
        if (en) begin
            if (mux_bit_s) begin
                zero_len_d = {CNT_W{1'b0}};
            end else begin
                zero_len_d = sat_inc(zero_len_q);
            end
        end else begin
            zero_len_d = zero_len_q;
        end
    end

    // Zero-run counter register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            zero_len_q <= {CNT_W{1'b0}};
        end else begin
            zero_len_q <= zero_len_d;
        end
    end

    // Zero-run flag shares the threshold with the ones detector.
    always_comb begin
        zrun = thr_met(zero_len_q, thresh);
    end
`else
    // Feature disabled: no zero-run state, flag held low.
    always_comb begin
        zrun = 1'b0;
    end
`endif

    // Output drive.
    always_comb begin
        SEL     = sel_q;
        mux_bit = mux_bit_s;
        sr_out  = sr_q;
        run_len = run_len_q;
        consec  = consec_s;
        rise    = consec_s & ~consec_dly_q;
    end

endmodule

// File: tb/tb_consec_run_detector.sv
module tb_consec_run_detector;

    localparam int LANES = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int SEL_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             en_v;
    logic [LANES-1:0] lanes_v;
    logic [CNT_W-1:0] thresh_v;
    logic [SEL_W-1:0] sel_o;
    logic             mux_o;
    logic [DEPTH-1:0] sr_o;
    logic [CNT_W-1:0] run_o;
    logic             consec_o;
    logic             rise_o;
    logic             zrun_o;

    int ntests = 0;
    int nfail  = 0;

    consec_run_detector #(.LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST(rst), .en(en_v), .lanes_in(lanes_v), .thresh(thresh_v),
        .SEL(sel_o), .mux_bit(mux_o), .sr_out(sr_o), .run_len(run_o),
        .consec(consec_o), .rise(rise_o), .zrun(zrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // The model remembers the sampled bit stream since the last reset and
    // derives every output from it.
    bit hist[$];
    int nsamp = 0;
    bit cd    = 1'b0;
    bit valid = 1'b0;

    function automatic int trail(bit v);
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != v) break;
            n++;
        end
        return (n > CMAX) ? CMAX : n;
    endfunction

    function automatic bit m_consec();
        return (thresh_v != 0) && (trail(1'b1) >= int'(thresh_v));
    endfunction

    function automatic bit m_zrun();
`ifdef CONSEC_ZERO_DET_EN
        return (thresh_v != 0) && (trail(1'b0) >= int'(thresh_v));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [DEPTH-1:0] m_sr();
        logic [DEPTH-1:0] r = '0;
        for (int i = 0; i < DEPTH; i++)
            if (i < hist.size()) r[i] = hist[hist.size() - 1 - i];
        return r;
    endfunction

    always @(posedge clk) begin
        bit ncd;
        ncd = rst ? 1'b0 : m_consec();
        if (rst) begin
            hist.delete();
            nsamp = 0;
            valid = 1'b1;
        end else if (en_v) begin
            hist.push_back(lanes_v[nsamp % LANES]);
            if (hist.size() > 300) void'(hist.pop_front());
            nsamp++;
        end
        cd = ncd;
    end

    task automatic chk(string name, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (valid) begin
            bit mc;
            mc = m_consec();
            chk("SEL",     int'(sel_o),    nsamp % LANES);
            chk("mux_bit", int'(mux_o),    int'(lanes_v[nsamp % LANES]));
            chk("sr_out",  int'(sr_o),     int'(m_sr()));
            chk("run_len", int'(run_o),    trail(1'b1));
            chk("consec",  int'(consec_o), int'(mc));
            chk("rise",    int'(rise_o),   int'(mc & ~cd));
            chk("zrun",    int'(zrun_o),   int'(m_zrun()));
        end
    end

    // Drive one edge's inputs, run the edge, return at posedge+2.
    task automatic cyc(bit r, bit e, logic [LANES-1:0] l, logic [CNT_W-1:0] t);
        rst = r; en_v = e; lanes_v = l; thresh_v = t;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en_v = 1'b1; lanes_v = 4'hF; thresh_v = 8'd4;

        // Reset
        cyc(1'b1, 1'b1, 4'hF, 8'd4);
        cyc(1'b1, 1'b1, 4'hF, 8'd4);
        chk("rst_sel", int'(sel_o), 0);
        chk("rst_sr",  int'(sr_o), 0);
        chk("rst_run", int'(run_o), 0);
        chk("rst_consec", int'(consec_o), 0);
        chk("rst_rise", int'(rise_o), 0);
        chk("rst_zrun", int'(zrun_o), 0);

        // All ones, threshold 4
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b0, 1'b1, 4'b1111, 8'd4);
            if (k <= 4) chk("ones_run", int'(run_o), k);
            if (k == 3) chk("ones_consec3", int'(consec_o), 0);
            if (k == 4) begin
                chk("ones_consec4", int'(consec_o), 1);
                chk("ones_rise4", int'(rise_o), 1);
                chk("ones_sr4", int'(sr_o), 8'h0F);
            end
            if (k == 5) chk("ones_rise5", int'(rise_o), 0);
        end
        chk("ones_sr8", int'(sr_o), 8'hFF);

        // Pattern with no detection
        cyc(1'b1, 1'b1, 4'b0100, 8'd4);
        for (int k = 0; k < 8; k++) begin
            chk("pat_sel", int'(sel_o), k % 4);
            chk("pat_mux", int'(mux_o), ((k % 4) == 2) ? 1 : 0);
            cyc(1'b0, 1'b1, 4'b0100, 8'd4);
            chk("pat_consec", int'(consec_o), 0);
        end
        chk("pat_sr", int'(sr_o), 8'h22);

        // Saturation and disable
        cyc(1'b1, 1'b1, 4'hF, 8'd255);
        for (int k = 1; k <= 300; k++) begin
            cyc(1'b0, 1'b1, 4'hF, 8'd255);
            if (k == 254) chk("sat_consec254", int'(consec_o), 0);
            if (k == 255) begin
                chk("sat_consec255", int'(consec_o), 1);
                chk("sat_rise255", int'(rise_o), 1);
            end
        end
        chk("sat_run", int'(run_o), 255);
        thresh_v = 8'd0;
        #1;
        chk("dis_consec", int'(consec_o), 0);
        chk("dis_rise", int'(rise_o), 0);
        cyc(1'b0, 1'b1, 4'hF, 8'd0);
        chk("dis_rise_next", int'(rise_o), 0);

        // Enable gating
        cyc(1'b1, 1'b1, 4'hF, 8'd4);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'hF, 8'd4);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 4'hF, 8'd4);
            chk("hold_run", int'(run_o), 3);
            chk("hold_sel", int'(sel_o), 3);
        end
        cyc(1'b0, 1'b1, 4'hF, 8'd4);
        chk("en_consec", int'(consec_o), 1);
        chk("en_rise", int'(rise_o), 1);

        // Mid-run reset at run_len 3
        cyc(1'b1, 1'b1, 4'hF, 8'd4);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 4'hF, 8'd4);
        chk("mid_run3", int'(run_o), 3);
        cyc(1'b1, 1'b1, 4'hF, 8'd4);
        chk("mid_run", int'(run_o), 0);
        chk("mid_sr", int'(sr_o), 0);
        chk("mid_sel", int'(sel_o), 0);
        chk("mid_rise", int'(rise_o), 0);

        // Zero-run
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 4'b0000, 8'd4);
`ifdef CONSEC_ZERO_DET_EN
        chk("zrun4", int'(zrun_o), 1);
`else
        chk("zrun4", int'(zrun_o), 0);
`endif

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            logic [CNT_W-1:0] t;
            t = thresh_v;
            if ($urandom_range(0, 19) == 0) t = CNT_W'($urandom_range(0, 6));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                LANES'($urandom | $urandom), t);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
